cnn_test_streamer: RTL
======================

// Module: cnn_test_streamer
// PURPOSE
//  Stimulus and result end of the CNN accelerator's pixel interface. Reads
//  test images from a pixel ROM and streams each 28x28 image, one 8-bit pixel
//  per clock, into the CNN top. It then waits for the top's finish pulse,
//  captures the 4-bit decision, compares it with the ROM label, and counts
//  correct classifications over NUM_IMAGES images.
//  The CNN's conv1 stage has no valid input, so this block frames each image
//  by holding the CNN in reset between images.
// PARAMETERS
//  IMG_PIXELS  784   pixels per image, streamed back-to-back
//  NUM_IMAGES  1000  images per run
//  ADDR_BITS   20    pixel ROM address width (>= clog2(IMG_PIXELS*NUM_IMAGES))
//  IDX_BITS    10    image index width (>= clog2(NUM_IMAGES))
//  RST_CYCLES  4     cycles cnn_rst_n is held low before each image (>=1)
//  TIMEOUT     4096  max cycles from last pixel to finish before a forced miss
// PORTS
//  clk            in   1          system clock
//  rst_n          in   1          async active-low reset
//  start          in   1          pulse: begin run (honoured in IDLE/DONE only)
//  pix_addr       out  ADDR_BITS  pixel ROM address, sync read, 1-cycle latency
//  pix_rdata      in   8          pixel ROM data (for pix_addr of previous cycle)
//  lbl_addr       out  IDX_BITS   label ROM address, sync read, 1-cycle latency
//  lbl_rdata      in   4          label ROM data
//  cnn_rst_n      out  1          reset to the CNN top, active low
//  cnn_data       out  8          pixel to the CNN top data_in
//  cnn_decision   in   4          CNN decision
//  cnn_finish     in   1          CNN finish pulse
//  busy           out  1          run in progress
//  done           out  1          level: run complete, held until next start
//  img_index      out  IDX_BITS   image currently processed
//  res_valid      out  1          1-cycle pulse per image result
//  res_decision   out  4          decision for that image (4'hF = timeout)
//  res_correct    out  1          res_decision == label
//  correct_count  out  IDX_BITS+1 running count of correct images
// BEHAVIOUR
//  Reset values
//  - All outputs are 0 except cnn_rst_n (0, CNN held in reset).
//  - FSM returns to IDLE. Reset mid-run aborts and clears all counters.
//  FSM states
//  - IDLE
//    - start: clear correct_count and img_index, go to CNN_RST.
//  - CNN_RST
//    - cnn_rst_n=0 for RST_CYCLES cycles; cnn_data=0.
//    - On the last cycle, drive pix_addr = img_index*IMG_PIXELS (prefetch).
//  - STREAM
//    - cnn_rst_n=1. On cycle k (k=0..IMG_PIXELS-1), cnn_data = pix_rdata =
//      pixel k, with no gaps.
//    - pix_addr leads by one cycle.
//    - The base address is an accumulator that adds IMG_PIXELS per image
//      (no multiplier).
//    - After pixel IMG_PIXELS-1, go to WAIT.
//  - WAIT
//    - cnn_data=0; lbl_addr=img_index; timeout counter runs.
//    - The first cnn_finish seen in STREAM or WAIT captures cnn_decision;
//      later pulses are ignored.
//    - On capture, or when the counter reaches TIMEOUT (decision forced to
//      4'hF), go to SCORE.
//  - SCORE (1 cycle)
//    - Pulse res_valid; compare with lbl_rdata.
//    - If correct, correct_count+1.
//    - If img_index==NUM_IMAGES-1, go to DONE; else img_index+1 and go to
//      CNN_RST.
//  - DONE
//    - done=1, busy=0, cnn_rst_n=0.
//    - start: clear counters/done and go to CNN_RST.
//  Other rules
//  - busy=1 in CNN_RST, STREAM, WAIT and SCORE. start while busy is ignored.
//  - All outputs are registered except cnn_data, which is a pass-through of
//    pix_rdata gated to 0 outside STREAM.
//  - correct_count saturates at NUM_IMAGES by construction; no wrap.
// TESTING
//  - IMG_PIXELS=4, NUM_IMAGES=2, ROM pixels 1..8, start -> cnn_data 1,2,3,4
//    on consecutive cnn_rst_n-high cycles, then 5,6,7,8 after >=4 reset cycles.
//  - Model finish 10 cycles after the last pixel with decision=label -> two
//    res_valid pulses, res_correct=1, correct_count=2, done=1.
//  - Decision 3 vs label 7 -> res_correct=0, res_decision=3, count unchanged.
//  - No finish, TIMEOUT=16 -> res_decision=4'hF exactly 16 cycles after WAIT
//    entry, res_correct=0.
//  - finish pulsed twice (decisions 2 then 5) -> res_decision=2.
//  - rst_n low mid-STREAM -> outputs zero, cnn_rst_n=0; start is ignored while
//    busy; start in DONE reruns from image 0 with count cleared.

Source files
------------

// File: rtl/cnn_test_streamer.sv
// Test-image streamer and result scorer for the CNN accelerator.
// It streams each image from a synchronous pixel ROM into the CNN one pixel
// per clock. The CNN is held in reset between images, which frames each image.
// After an image it captures the CNN decision, or forces 4'hF on timeout,
// scores that decision against the label ROM and counts correct results.
//
// Handshake: none on the pixel side. The CNN takes one pixel every cycle
// that cnn_rst_n is high and cnn_data carries a pixel. The result side has no
// back-pressure: res_valid is high for exactly one cycle per image, and
// res_decision, res_correct and correct_count are stable in that cycle.
module cnn_test_streamer #(
    parameter int IMG_PIXELS = 784,
    parameter int NUM_IMAGES = 1000,
    parameter int ADDR_BITS  = 20,
    parameter int IDX_BITS   = 10,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [ADDR_BITS-1:0] pix_addr,
    input  logic [7:0]           pix_rdata,
    output logic [IDX_BITS-1:0]  lbl_addr,
    input  logic [3:0]           lbl_rdata,
    output logic                 cnn_rst_n,
    output logic [7:0]           cnn_data,
    input  logic [3:0]           cnn_decision,
    input  logic                 cnn_finish,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_BITS-1:0]  img_index,
    output logic                 res_valid,
    output logic [3:0]           res_decision,
    output logic                 res_correct,
    output logic [IDX_BITS:0]    correct_count
);

    localparam int PC_W = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);

    localparam logic [PC_W-1:0]      PIX_LAST   = PC_W'(IMG_PIXELS - 1);
    localparam logic [RC_W-1:0]      RST_LAST   = RC_W'(RST_CYCLES - 1);
    localparam logic [TO_W-1:0]      TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [ADDR_BITS-1:0] IMG_STRIDE = ADDR_BITS'(IMG_PIXELS);
    localparam logic [IDX_BITS-1:0]  IDX_LAST   = IDX_BITS'(NUM_IMAGES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNN_RST,
        S_STREAM,
        S_WAIT,
        S_SCORE,
        S_DONE
    } state_t;

    // The state register is named so that checkers can bind to it.
    state_t                 state;
    logic [ADDR_BITS-1:0]   base;      // first pixel address of the current image
    logic [RC_W-1:0]        rst_cnt;
    logic [PC_W-1:0]        pix_cnt;
    logic [TO_W-1:0]        to_cnt;
    logic                   captured;  // a finish pulse has been seen for this image
    logic [3:0]             cap_dec;

    logic                   wait_hit;
    logic                   wait_miss;
    logic [3:0]             wait_dec;

    // The pixel is passed straight through while streaming and is zero at all other times.
    assign cnn_data = (state == S_STREAM) ? pix_rdata : 8'h00;

    // Decide how WAIT ends: an earlier capture wins, then a finish in this cycle, then the timeout.
    always_comb begin
        wait_hit  = 1'b0;
        wait_miss = 1'b0;
        wait_dec  = 4'hF;
        if (captured) begin
            wait_hit = 1'b1;
            wait_dec = cap_dec;
        end else if (cnn_finish) begin
            wait_hit = 1'b1;
            wait_dec = cnn_decision;
        end else if (to_cnt == TO_LAST) begin
            wait_hit  = 1'b1;
            wait_miss = 1'b1;
        end
    end

    // Run-control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            base          <= '0;
            rst_cnt       <= '0;
            pix_cnt       <= '0;
            to_cnt        <= '0;
            captured      <= 1'b0;
            cap_dec       <= 4'h0;
            pix_addr      <= '0;
            lbl_addr      <= '0;
            cnn_rst_n     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            img_index     <= '0;
            res_valid     <= 1'b0;
            res_decision  <= 4'h0;
            res_correct   <= 1'b0;
            correct_count <= '0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state         <= S_CNN_RST;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        correct_count <= '0;
                        img_index     <= '0;
                        lbl_addr      <= '0;
                        base          <= '0;
                        pix_addr      <= '0;
                        rst_cnt       <= '0;
                        cnn_rst_n     <= 1'b0;
                    end
                end
                S_CNN_RST: begin
                    // pix_addr has held the image base since entry, so the ROM
                    // already has pixel 0 when streaming begins.
                    if (rst_cnt == RST_LAST) begin
                        state     <= S_STREAM;
                        cnn_rst_n <= 1'b1;
                        pix_addr  <= pix_addr + ADDR_BITS'(1);
                        pix_cnt   <= '0;
                        captured  <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + RC_W'(1);
                    end
                end
                S_STREAM: begin
                    if (cnn_finish && !captured) begin
                        captured <= 1'b1;
                        cap_dec  <= cnn_decision;
                    end
                    if (pix_cnt == PIX_LAST) begin
                        state  <= S_WAIT;
                        to_cnt <= '0;
                    end else begin
                        pix_cnt  <= pix_cnt + PC_W'(1);
                        pix_addr <= pix_addr + ADDR_BITS'(1);
                    end
                end
                S_WAIT: begin
                    if (wait_hit) begin
                        state        <= S_SCORE;
                        captured     <= 1'b1;
                        res_valid    <= 1'b1;
                        res_decision <= wait_dec;
                        res_correct  <= !wait_miss && (wait_dec == lbl_rdata);
                        if (!wait_miss && (wait_dec == lbl_rdata)) begin
                            correct_count <= correct_count + (IDX_BITS + 1)'(1);
                        end
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_SCORE: begin
                    if (img_index == IDX_LAST) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cnn_rst_n <= 1'b0;
                    end else begin
                        state     <= S_CNN_RST;
                        img_index <= img_index + IDX_BITS'(1);
                        lbl_addr  <= img_index + IDX_BITS'(1);
                        base      <= base + IMG_STRIDE;
                        pix_addr  <= base + IMG_STRIDE;
                        rst_cnt   <= '0;
                        cnn_rst_n <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
